// File: rtl/pn_tx.sv
// Token transmitter for an expression evaluator: serialises latched operators and
// operands in one of four orderings, then collects the evaluator's result beats.
`timescale 1ns/1ps

module pn_tx #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [1:0]         cnt,
    input  logic [7:0]         op_bus,
    input  logic [23:0]        opd_bus,
    output logic               tx_valid,
    output logic [1:0]         tx_mode,
    output logic               tx_operator,
    output logic [2:0]         tx_in,
    input  logic               rx_valid,
    input  logic signed [31:0] rx_data,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [2:0]         res_cnt,
    output logic signed [31:0] res_last
);

    localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [7:0]         ops_q, ops_d;
    logic [23:0]        opd_q, opd_d;
    logic [3:0]         idx_q, idx_d;
    logic [1:0]         grp_q, grp_d;
    logic [1:0]         pos_q, pos_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic [2:0]         res_cnt_q, res_cnt_d;
    logic signed [31:0] res_last_q, res_last_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic [1:0] op_arr  [4];
    logic [2:0] opd_arr [8];
    logic [1:0] op_sel;
    logic [2:0] opd_sel;
    logic       tok_is_op;
    logic [2:0] tok_val;
    logic [2:0] n_ops;
    logic [3:0] last_idx;
    logic [2:0] exp_res;
    logic [2:0] res_cnt_inc;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) op_arr[k] = ops_q[2*k +: 2];
        for (int unsigned k = 0; k < 8; k++) opd_arr[k] = opd_q[3*k +: 3];
    end

    assign n_ops       = {1'b0, cnt_q} + 3'd1;
    assign exp_res     = mode_q[1] ? 3'd1 : n_ops;
    assign last_idx    = mode_q[1] ? ({1'b0, cnt_q, 1'b0} + 4'd2)
                                   : ({2'b00, cnt_q} * 4'd3 + 4'd2);
    assign res_cnt_inc = res_cnt_q + 3'd1;

    // Grouped modes walk (group, position) counters; chained modes decode from the flat index.
    always_comb begin
        tok_is_op = 1'b0;
        op_sel    = '0;
        opd_sel   = '0;
        case (mode_q)
            2'd0: begin
                case (pos_q)
                    2'd0:    begin tok_is_op = 1'b1; op_sel = grp_q; end
                    2'd1:    opd_sel = {grp_q, 1'b0};
                    default: opd_sel = {grp_q, 1'b1};
                endcase
            end
            2'd1: begin
                case (pos_q)
                    2'd0:    opd_sel = {grp_q, 1'b0};
                    2'd1:    opd_sel = {grp_q, 1'b1};
                    default: begin tok_is_op = 1'b1; op_sel = grp_q; end
                endcase
            end
            2'd2: begin
                if (idx_q < {1'b0, n_ops}) begin
                    tok_is_op = 1'b1;
                    op_sel    = cnt_q - idx_q[1:0];
                end else begin
                    opd_sel = idx_q[2:0] - n_ops;
                end
            end
            default: begin
                if (idx_q < 4'd2) begin
                    opd_sel = idx_q[2:0];
                end else if (!idx_q[0]) begin
                    tok_is_op = 1'b1;
                    op_sel    = idx_q[2:1] - 2'd1;
                end else begin
                    opd_sel = idx_q[3:1] + 3'd1;
                end
            end
        endcase
        tok_val = tok_is_op ? {1'b0, op_arr[op_sel]} : opd_arr[opd_sel];
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        ops_d      = ops_q;
        opd_d      = opd_q;
        idx_d      = idx_q;
        grp_d      = grp_q;
        pos_d      = pos_q;
        wcnt_d     = wcnt_q;
        res_cnt_d  = res_cnt_q;
        res_last_d = res_last_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SEND;
                    mode_d     = mode;
                    cnt_d      = cnt;
                    ops_d      = op_bus;
                    opd_d      = opd_bus;
                    idx_d      = '0;
                    grp_d      = '0;
                    pos_d      = '0;
                    res_cnt_d  = '0;
                    res_last_d = '0;
                    timeout_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (idx_q == last_idx) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (pos_q == 2'd2) begin
                        pos_d = '0;
                        grp_d = grp_q + 2'd1;
                    end else begin
                        pos_d = pos_q + 2'd1;
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (rx_valid) begin
                    res_cnt_d  = res_cnt_inc;
                    res_last_d = rx_data;
                end
                // Completion takes priority over an expiring wait budget.
                if (rx_valid && (res_cnt_inc == exp_res)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            cnt_q      <= '0;
            ops_q      <= '0;
            opd_q      <= '0;
            idx_q      <= '0;
            grp_q      <= '0;
            pos_q      <= '0;
            wcnt_q     <= '0;
            res_cnt_q  <= '0;
            res_last_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            ops_q      <= ops_d;
            opd_q      <= opd_d;
            idx_q      <= idx_d;
            grp_q      <= grp_d;
            pos_q      <= pos_d;
            wcnt_q     <= wcnt_d;
            res_cnt_q  <= res_cnt_d;
            res_last_q <= res_last_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_valid    = (state_q == S_SEND);
    assign tx_operator = tx_valid & tok_is_op;
    assign tx_in       = tx_valid ? tok_val : '0;
    assign tx_mode     = tx_valid ? mode_q : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign res_cnt     = res_cnt_q;
    assign res_last    = res_last_q;

endmodule

// File: tb/tb_pn_tx.sv
// Scoreboard bench for pn_tx: expected tokens are queued at start and popped as tokens appear.
`timescale 1ns/1ps

module tb_pn_tx;

    localparam int unsigned TO = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [1:0]         mode;
    logic [1:0]         cnt;
    logic [7:0]         op_bus;
    logic [23:0]        opd_bus;
    logic               tx_valid;
    logic [1:0]         tx_mode;
    logic               tx_operator;
    logic [2:0]         tx_in;
    logic               rx_valid;
    logic signed [31:0] rx_data;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [2:0]         res_cnt;
    logic signed [31:0] res_last;

    pn_tx #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cnt(cnt),
        .op_bus(op_bus), .opd_bus(opd_bus), .tx_valid(tx_valid), .tx_mode(tx_mode),
        .tx_operator(tx_operator), .tx_in(tx_in), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .done(done), .timeout(timeout), .res_cnt(res_cnt), .res_last(res_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       op;
        logic [2:0] val;
        logic [1:0] mode;
    } tok_t;

    tok_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic op, input logic [2:0] v, input logic [1:0] m);
        tok_t t;
        t.op   = op;
        t.val  = v;
        t.mode = m;
        exp_q.push_back(t);
    endtask

    task automatic push_stream(input logic [1:0] m, input logic [1:0] c,
                               input logic [7:0] ops, input logic [23:0] opd);
        int         n;
        logic [2:0] a [8];
        logic [1:0] o [4];
        n = int'(c) + 1;
        for (int k = 0; k < 8; k++) a[k] = opd[3*k +: 3];
        for (int k = 0; k < 4; k++) o[k] = ops[2*k +: 2];
        case (m)
            2'd0: for (int i = 0; i < n; i++) begin
                push(1'b1, {1'b0, o[i]}, m); push(1'b0, a[2*i], m); push(1'b0, a[2*i+1], m);
            end
            2'd1: for (int i = 0; i < n; i++) begin
                push(1'b0, a[2*i], m); push(1'b0, a[2*i+1], m); push(1'b1, {1'b0, o[i]}, m);
            end
            2'd2: begin
                for (int i = n - 1; i >= 0; i--) push(1'b1, {1'b0, o[i]}, m);
                for (int k = 0; k <= n; k++) push(1'b0, a[k], m);
            end
            default: begin
                push(1'b0, a[0], m);
                for (int i = 0; i < n; i++) begin
                    push(1'b0, a[i+1], m); push(1'b1, {1'b0, o[i]}, m);
                end
            end
        endcase
    endtask

    always @(negedge clk) begin : monitor
        tok_t e;
        if (rst_n === 1'b1) begin
            if (tx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("tok_extra", {31'b0, tx_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tok_op",   {31'b0, tx_operator}, {31'b0, e.op});
                    check("tok_in",   {29'b0, tx_in},       {29'b0, e.val});
                    check("tok_mode", {30'b0, tx_mode},     {30'b0, e.mode});
                end
            end else begin
                check("idle_zero", {26'b0, tx_operator, tx_in, tx_mode}, 32'd0);
            end
        end
    end

    // Ends on the negedge of the first WAIT cycle.
    task automatic run_stream(input logic [1:0] m, input logic [1:0] c,
                              input logic [7:0] ops, input logic [23:0] opd, input bit poke);
        int unsigned len;
        int unsigned exp_len;
        push_stream(m, c, ops, opd);
        exp_len = m[1] ? 2 * (int'(c) + 1) + 1 : 3 * (int'(c) + 1);
        mode = m; cnt = c; op_bus = ops; opd_bus = opd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = ~m; cnt = ~c; op_bus = ~ops; opd_bus = ~opd;
        check("first_tok", {31'b0, tx_valid}, 32'd1);
        check("busy_send", {31'b0, busy}, 32'd1);
        check("to_clr", {31'b0, timeout}, 32'd0);
        check("res_clr", {29'b0, res_cnt}, 32'd0);
        len = 0;
        while (tx_valid === 1'b1 && len < 20) begin
            len++;
            start = (poke && len == 2);
            if (start) begin mode = ~m; op_bus = 8'h5A; opd_bus = 24'hABCDEF; end
            @(negedge clk);
        end
        start = 1'b0;
        check("tok_len", len, exp_len);
        check("tok_q_empty", exp_q.size(), 32'd0);
        check("busy_wait", {31'b0, busy}, 32'd1);
    endtask

    task automatic send_rx(input logic [31:0] d, input logic exp_done);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
        check("done", {31'b0, done}, {31'b0, exp_done});
    endtask

    task automatic finish_checks(input logic [2:0] exp_cnt, input logic [31:0] exp_last,
                                 input logic exp_to);
        check("res_cnt", {29'b0, res_cnt}, {29'b0, exp_cnt});
        check("res_last", res_last, exp_last);
        check("timeout", {31'b0, timeout}, {31'b0, exp_to});
        check("busy_idle", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned   cyc;
        logic [1:0]    m;
        logic [1:0]    c;
        logic [31:0]   d;
        int unsigned   beats;

        rst_n = 1'b0; start = 1'b0; mode = '0; cnt = '0; op_bus = '0; opd_bus = '0;
        rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check("rst_res_cnt", {29'b0, res_cnt}, 32'd0);
        check("rst_res_last", res_last, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Chained postfix: a0=3 a1=2 a2=4, op0=+ op1=*
        run_stream(2'd3, 2'd1, 8'h08, 24'h000113, 1'b0);
        send_rx(32'd20, 1'b1);
        finish_checks(3'd1, 32'd20, 1'b0);
        send_rx(32'd99, 1'b0);
        check("extra_cnt", {29'b0, res_cnt}, 32'd1);
        check("extra_last", res_last, 32'd20);

        // Chained prefix, same operands, with a start pulse during SEND
        run_stream(2'd2, 2'd1, 8'h08, 24'h000113, 1'b1);
        send_rx(-32'sd7, 1'b1);
        finish_checks(3'd1, -32'sd7, 1'b0);

        // Grouped prefix with four groups: done only after the fourth beat
        run_stream(2'd0, 2'd3, 8'hE4, 24'hFAC688, 1'b0);
        for (int b = 0; b < 4; b++) send_rx(32'(100 + b), logic'(b == 3));
        finish_checks(3'd4, 32'd103, 1'b0);

        // Grouped postfix single group: a0=5 a1=1 op0=-
        run_stream(2'd1, 2'd0, 8'h01, 24'h00000D, 1'b0);
        send_rx(32'd4, 1'b1);
        finish_checks(3'd1, 32'd4, 1'b0);

        // No results: timeout exactly TO cycles after WAIT entry
        run_stream(2'd0, 2'd0, 8'h02, 24'h00001F, 1'b0);
        cyc = 0;
        while (done !== 1'b1 && cyc < TO + 10) begin
            @(negedge clk);
            cyc++;
        end
        check("to_latency", cyc, TO);
        finish_checks(3'd0, 32'd0, 1'b1);

        // Completion on the same cycle the wait budget expires
        run_stream(2'd3, 2'd0, 8'h03, 24'h000015, 1'b0);
        repeat (TO - 1) @(negedge clk);
        send_rx(32'd55, 1'b1);
        finish_checks(3'd1, 32'd55, 1'b0);

        // Reset asserted mid-SEND
        push_stream(2'd0, 2'd3, 8'h1B, 24'h123456);
        mode = 2'd0; cnt = 2'd3; op_bus = 8'h1B; opd_bus = 24'h123456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_tx_in", {29'b0, tx_in}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomised transactions after reset release
        for (int t = 0; t < 8; t++) begin
            m = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            run_stream(m, c, 8'($urandom()), 24'($urandom()), logic'(t[0]));
            beats = m[1] ? 1 : int'(c) + 1;
            d = '0;
            for (int b = 0; b < int'(beats); b++) begin
                d = $urandom();
                send_rx(d, logic'(b == int'(beats) - 1));
            end
            finish_checks(3'(beats), d, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pn_tx.md
PN_TX -- requirements
Module: pn_tx

Interface
REQ-001 Parameter TIMEOUT, default 255, max WAIT-state cycles before aborting the result collection.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 mode  input  2  0 = grouped prefix, 1 = grouped postfix, 2 = chained prefix, 3 = chained postfix.
REQ-006 cnt  input  2  n-1, where n = number of operators (1..4).
REQ-007 op_bus  input  8  four 2-bit operator codes; op_i = op_bus[2i+1:2i]; 0 = +, 1 = -, 2 = *, 3 = |a+b|.
REQ-008 opd_bus  input  24  eight 3-bit operands; a_k = opd_bus[3k+2:3k].
REQ-009 tx_valid  output  1  token valid; drives the evaluator's in_valid.
REQ-010 tx_mode  output  2  latched mode; drives the evaluator's mode.
REQ-011 tx_operator  output  1  1 = token is an operator, 0 = token is an operand.
REQ-012 tx_in  output  3  token value; an operator code is zero-extended to 3 bits.
REQ-013 rx_valid  input  1  evaluator out_valid.
REQ-014 rx_data  input  32 signed  evaluator out.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a transaction ends.
REQ-017 timeout  output  1  sticky abort flag; cleared on the next accepted start.
REQ-018 res_cnt  output  3  number of rx_valid beats collected.
REQ-019 res_last  output  32 signed  rx_data of the most recent collected beat.

Function
REQ-020 FSM states and transitions:
- IDLE -> SEND on start.
- SEND -> WAIT after the last token.
- WAIT -> IDLE on completion or timeout.
REQ-021 On an accepted start: latch mode, cnt, op_bus and opd_bus; clear res_cnt, res_last and timeout.
REQ-022 start SHALL be ignored while busy; latched values SHALL NOT change until the next accepted start.
REQ-023 The first token SHALL appear (tx_valid=1) in the cycle after the start edge; tokens are contiguous, one per cycle, with no gaps.
REQ-024 Mode 0 stream, for group i = 0..n-1: op_i, a_2i, a_2i+1 (3n tokens).
REQ-025 Mode 1 stream, for group i = 0..n-1: a_2i, a_2i+1, op_i (3n tokens).
REQ-026 Mode 3 stream: a0, a1, op0, a2, op1, ..., a_n, op_n-1 (2n+1 tokens).
REQ-027 Mode 2 stream: op_n-1, ..., op0, a0, a1, ..., a_n (2n+1 tokens).
REQ-028 When tx_valid=0, tx_operator, tx_in and tx_mode SHALL be 0.
REQ-029 tx_valid SHALL be low in the cycle after the last token, giving at least one idle cycle before results.
REQ-030 Expected result count is n for modes 0/1 and 1 for modes 2/3.
REQ-031 In WAIT, each rx_valid=1 cycle SHALL increment res_cnt and load res_last<=rx_data; rx_valid outside WAIT is ignored.
REQ-032 When res_cnt reaches the expected count, go to IDLE and pulse done in the same cycle as the transition register update.
REQ-033 A WAIT cycle counter starts at 0 on WAIT entry; at TIMEOUT cycles without completion, set timeout=1, pulse done and go to IDLE.
REQ-034 If completion and timeout occur in the same cycle, completion wins (timeout stays 0).
REQ-035 Extra rx_valid beats after completion SHALL be ignored.

Reset
REQ-036 rst_n low, at any time including mid-SEND/WAIT, SHALL immediately force IDLE and set all outputs and counters to 0.
REQ-037 The first start after reset release SHALL be accepted normally.

Verification
REQ-038 mode=3, cnt=1, op0=0, op1=2, a0=3, a1=2, a2=4 -> tokens (op,in) = (0,3)(0,2)(1,0)(0,4)(1,2); one rx beat of 20 -> done, res_cnt=1, res_last=20.
REQ-039 Same operands with mode=2 -> tokens (1,2)(1,0)(0,3)(0,2)(0,4); tx_mode=2 on every token.
REQ-040 mode=0, cnt=3 -> 12 contiguous tokens in op,a,b order per group; 4 rx beats -> done only after the 4th beat; res_cnt=4.
REQ-041 mode=1, cnt=0, a0=5, a1=1, op0=1 -> tokens (0,5)(0,1)(1,1); rx beat of 4 -> res_last=4.
REQ-042 No rx_valid -> done and timeout=1 exactly TIMEOUT cycles after WAIT entry; next start clears timeout.
REQ-043 start pulsed mid-SEND -> stream unchanged; rst_n asserted mid-SEND -> tx_valid=0 immediately, busy=0.
